// File: rtl/mux_nto1_skid_pkg.sv
// Shared types and constants for the N-to-1 select stage with skid buffer.
// Also holds the operand-forwarding select encodings used by the CPU datapath.
package mux_nto1_skid_pkg;

    localparam int WIDTH_DEF = 32;

    // Operand-forwarding select encodings
    localparam int FWD_RF    = 0;
    localparam int FWD_EXMEM = 1;
    localparam int FWD_MEMWB = 2;
    localparam int FWD_IMM   = 3;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

    function automatic logic sel_in_range(input int sel, input int num_in);
        return (sel < num_in);
    endfunction

endpackage

// File: rtl/mux_nto1_skid_mux.sv
// Combinational N-to-1 word selector; out-of-range selects yield an all-zero word.
module mux_nto1
    import mux_nto1_skid_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic [NUM_IN*WIDTH-1:0] data_i,
    input  logic [SEL_W-1:0]        select_i,
    output logic [WIDTH-1:0]        data_o,
    output logic                    out_of_range_o
);

    logic [WIDTH-1:0] words [NUM_IN];

    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_unpack
        assign words[gi] = data_i[gi*WIDTH +: WIDTH];
    end

    always_comb begin
        data_o = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (select_i == SEL_W'(k)) begin
                data_o = words[k];
            end
        end
    end

    assign out_of_range_o = !sel_in_range(int'(select_i), NUM_IN);

endmodule

// File: rtl/mux_nto1_skid.sv
// N-to-1 select with registered output, valid/ready handshake and a 2-entry skid
// buffer (MAIN drives data_o, SKID catches the word arriving during a stall).
module mux_nto1_skid
    import mux_nto1_skid_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_IN*WIDTH-1:0] data_i,
    input  logic [SEL_W-1:0]        select_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic                    flush_i,
    output logic [WIDTH-1:0]        data_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    sel_err_o
);

    if (SEL_W != $clog2(NUM_IN) || NUM_IN < 2 || NUM_IN > 16) begin : g_bad_param
        $error("mux_nto1_skid: need 2 <= NUM_IN <= 16 and SEL_W == $clog2(NUM_IN)");
    end

    skid_state_e      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             sel_err_q, sel_err_d;

    logic [WIDTH-1:0] sel_word;
    logic             sel_oor;
    logic             accept;
    logic             pop;

    mux_nto1 #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_mux (
        .data_i         (data_i),
        .select_i       (select_i),
        .data_o         (sel_word),
        .out_of_range_o (sel_oor)
    );

    assign accept = valid_i & ready_o;
    assign pop    = valid_o & ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_EMPTY: if (accept) state_d = ST_ONE;
            ST_ONE: begin
                if (accept && !pop) begin
                    state_d = ST_TWO;
                end else if (pop && !accept) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO:   if (pop) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
        endcase
        if (flush_i) begin
            state_d = ST_EMPTY;
        end
    end

    // Handshake outputs come from registered state only, so ready_o never
    // combinationally depends on ready_i.
    always_comb begin
        ready_o = (state_q != ST_TWO);
        valid_o = (state_q != ST_EMPTY);
    end

    always_comb begin
        main_d    = main_q;
        skid_d    = skid_q;
        sel_err_d = accept & sel_oor;
        if (flush_i) begin
            main_d = '0;
            skid_d = '0;
        end else begin
            unique case (state_q)
                ST_EMPTY: if (accept) main_d = sel_word;
                ST_ONE: begin
                    if (accept && pop) begin
                        main_d = sel_word;
                    end else if (accept) begin
                        skid_d = sel_word;
                    end
                end
                ST_TWO:   if (pop) main_d = skid_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_q    <= '0;
            skid_q    <= '0;
            sel_err_q <= 1'b0;
        end else begin
            main_q    <= main_d;
            skid_q    <= skid_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign data_o    = main_q;
    assign sel_err_o = sel_err_q;

endmodule
